// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface priority_arbiter_if;
  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_id;
  logic             valid;

  modport master (output en, req, input gnt, gnt_id, valid);
  modport slave  (input en, req, output gnt, gnt_id, valid);
endinterface

// File: rtl/priority_arbiter.sv
// Registered 8-requester arbiter with hold-limit preemption.
// Bit 7 is the highest priority. Define ROUND_ROBIN_EN to rotate the search
// start from the last winner; leave it undefined for fixed priority 7 > ... > 0.
module priority_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  priority_arbiter_if.slave  bus
);
  localparam int unsigned N_REQ  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned HOLD_W = 8;
  localparam bit          PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   gnt_q, gnt_nxt;
  logic [IDX_W-1:0]   id_q, id_nxt;
  logic               valid_q, valid_nxt;
  logic [HOLD_W-1:0]  hold_q, hold_nxt;
  logic [IDX_W-1:0]   last_q, last_nxt;

  logic               load;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   search_base;
  logic [N_REQ-1:0]   owner_bit;
  logic [N_REQ-1:0]   others;
  logic               found_all, found_oth;
  logic [IDX_W-1:0]   pick_all, pick_oth;
  logic               preempt;

  // Search starts at base-1 and descends with wraparound, ending at base.
  // With base 0 this is exactly fixed priority 7,6,...,0.
  function automatic logic [IDX_W:0] pick(input logic [N_REQ-1:0] cand,
                                          input logic [IDX_W-1:0] base);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = base - IDX_W'(k);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef ROUND_ROBIN_EN
  assign search_base = last_q;
`else
  assign search_base = '0;
`endif

  assign owner_bit = N_REQ'(1) << id_q;
  assign others    = bus.req & ~owner_bit;
  assign {found_all, pick_all} = pick(bus.req, search_base);
  assign {found_oth, pick_oth} = pick(others, search_base);
  assign preempt = PREEMPT_EN && (hold_q == HOLD_LAST) && found_oth;

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
      last_q  <= '0;
    end else begin
      state   <= state_nxt;
      gnt_q   <= gnt_nxt;
      id_q    <= id_nxt;
      valid_q <= valid_nxt;
      hold_q  <= hold_nxt;
      last_q  <= last_nxt;
    end
  end

  // Next state and the winner to load (if any).
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    win       = id_q;
    case (state)
      IDLE: begin
        if (bus.en && found_all) begin
          state_nxt = GRANT;
          load      = 1'b1;
          win       = pick_all;
        end
      end
      GRANT: begin
        if (!bus.en) begin
          state_nxt = IDLE;
        end else if (!bus.req[id_q]) begin
          if (found_oth) begin
            load = 1'b1;
            win  = pick_oth;
          end else begin
            state_nxt = IDLE;
          end
        end else if (preempt) begin
          load = 1'b1;
          win  = pick_oth;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of grant outputs, hold counter and last-grant pointer.
  always_comb begin
    gnt_nxt   = '0;
    id_nxt    = '0;
    valid_nxt = 1'b0;
    hold_nxt  = '0;
    last_nxt  = last_q;
    if (state_nxt == GRANT) begin
      gnt_nxt   = N_REQ'(1) << win;
      id_nxt    = win;
      valid_nxt = 1'b1;
      if (load) begin
        last_nxt = win;
      end else if (hold_q < HOLD_LAST) begin
        hold_nxt = hold_q + HOLD_W'(1);
      end else begin
        hold_nxt = hold_q;
      end
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = id_q;
  assign bus.valid  = valid_q;

  // The pointer always tracks the current owner while a grant is active.
  a_ptr_tracks_owner: assert property (@(posedge clk) disable iff (!rst_n)
    valid_q |-> (id_q == last_q));
endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

Registered 8-requester arbiter built around the team's 8:3 priority encoding convention, where bit 7 has the highest priority. It is the scheduler placed in front of a shared resource. Each cycle it samples a request vector, grants one requester, and holds that grant until the owner releases it or a hold limit preempts it. It outputs the grant as a one-hot vector plus a 3-bit binary index, so downstream logic can drive a mux select or the encoder-style index directly.

## Interface
- MAX_HOLD, 16, maximum consecutive grant cycles before preemption when other requests are pending; 0 disables preemption; legal range 0..255
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- en  input  1  arbiter enable; 0 forces the no-grant state
- req  input  8  request vector; a requester holds its bit high until done
- gnt  output  8  registered one-hot grant, or all zeros
- gnt_id  output  3  binary index of the set gnt bit; 3'd0 when gnt==0
- valid  output  1  registered, equals |gnt

## Operation
- State machine has two states.
  - IDLE: gnt==0.
  - GRANT: exactly one gnt bit is set; the current owner is held in an internal register.
- Reset (rst_n==0 at an edge) produces:
  - state IDLE; gnt=8'h00, gnt_id=3'd0, valid=0
  - hold counter = 0; last-grant pointer = 3'd0
- Arbitration function, called pick(mask): selects one index from req & mask, searching in priority order. The search order is set by the Configuration section.
- IDLE, en=1, req!=0: go to GRANT and grant pick(8'hFF).
- IDLE with en=0 or req==0: stay in IDLE.
- GRANT, en=0: go to IDLE and clear gnt. The pointer is unchanged.
- GRANT, req[owner]==0 (owner released):
  - if req with the owner bit masked is nonzero, grant pick(~owner_bit) and stay in GRANT (no idle bubble);
  - otherwise go to IDLE.
- GRANT, req[owner]==1, MAX_HOLD!=0, hold counter == MAX_HOLD-1, and another request is pending: preempt. Grant pick(~owner_bit).
- GRANT, req[owner]==1, and none of the above applies: keep the owner.
  - The hold counter increments and saturates at MAX_HOLD-1.
  - If no other request is pending, the owner keeps the grant indefinitely.
- Hold counter: cleared to 0 on every new grant and in IDLE. Width is 8 bits.
- Last-grant pointer: loaded with the winner index on every new grant.
- Requests with en=0 are ignored; no request state is stored.

## Timing
- Latency is 1 cycle. req/en sampled at edge N appear on gnt/gnt_id/valid after edge N.
- An owner that drops req at edge N sees gnt switched (or cleared) after edge N.
- The owner's grant lasts at most MAX_HOLD cycles while contention exists.
- gnt, gnt_id and valid always change together and are glitch-free (all registered).
- If reset and en/req are active on the same edge, reset wins.
- Reset mid-grant clears gnt on that edge; arbitration restarts from IDLE on the next edge.

## Configuration
- ROUND_ROBIN_EN defined: rotating priority.
  - Search order starts at (last-1) mod 8 and descends with wraparound, ending at last.
  - After reset (last=0), the order is 7,6,…,0, which is identical to fixed priority for the first grant.
- ROUND_ROBIN_EN undefined: fixed priority 7 > 6 > … > 0. The pointer is still maintained but not used for the search.
- The preemption mask (owner excluded) applies in both modes.

## Test plan
- Reset and idle check: rst_n=0 with req=8'hFF, then rst_n=1, en=1, req=8'h00. Required: gnt=0, gnt_id=0 and valid=0 throughout.
- Fixed-priority contention (macro undefined): en=1, req=8'b1001_0100. Required: next cycle gnt=8'h80, gnt_id=7. Then drop req[7]: next cycle gnt=8'h10, gnt_id=4, with no idle cycle.
- Round-robin rotation (ROUND_ROBIN_EN): hold req=8'b1000_0001, with each owner releasing after 1 cycle of grant and immediately re-requesting. Required grant sequence: 7, 0, 7, 0.
- Preemption with MAX_HOLD=4: req[3] and req[1] held high continuously. Required: gnt_id=3 for exactly 4 cycles, then 1 for 4 cycles, alternating. With only req[3] high, gnt_id=3 persists for more than 20 cycles.
- Enable drop: while gnt=8'h04, set en=0. Required: next cycle gnt=0, valid=0. Restoring en=1 with req=8'h04 gives gnt=8'h04 one cycle later.
- Reset mid-operation: while gnt=8'h20, assert rst_n=0 for 1 cycle with req unchanged. Required: gnt=0 after that edge, and gnt=8'h20 one cycle after rst_n returns high.
